align3_ctrl: RTL
================

Name: align3_ctrl

Overview:
- Top-level sequencer for three-sequence alignment. Runs the DP cube fill, then hands off to the traceback engine.
- Fill: walks every cell (i,j,k) of the (LEN+1)^3 score cube in dependency-safe raster order. Issues one cell at a time to the cell-compute unit using a valid/ready request and a wb_valid completion.
- Traceback: pulses tb_start, waits for tb_done with a watchdog, then reports done.
- Sits between the host start/done interface, the cell-compute unit and the traceback unit.

Parameters:
- LEN, 7, sequence length; cube indices run 0..LEN.
- IW, $clog2(LEN+1), index width.
- TB_TIMEOUT, 256, max cycles in TB_WAIT before a timeout error.
- CW, $clog2((LEN+1)**3+1), cell-count width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a full alignment
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the run completes (normal or timeout)
- cell_valid  out  1  cell request valid
- cell_ready  in  1  cell unit accepts the request
- cell_i, cell_j, cell_k  out  IW each  cell coordinates
- cell_init  out  1  boundary cell (any index ==0); unit writes the boundary score
- wb_valid  in  1  cell unit has written back the score of the accepted cell
- tb_start  out  1  one-cycle pulse to the traceback unit
- tb_done  in  1  traceback flag, rising edge = finished
- cells_done  out  CW  number of cells written back this run
- err_timeout  out  1  sticky; tb_done not seen within TB_TIMEOUT
- err_proto  out  1  sticky; wb_valid received outside WAIT_WB

Behaviour:
- Reset values: all outputs 0, coordinates 0, state IDLE. Reset mid-run aborts immediately, with no done pulse.
- IDLE:
  - start=1 → clear cells_done, err_timeout and err_proto; coordinates=(0,0,0); go to ISSUE.
  - start while busy is ignored.
- ISSUE:
  - cell_valid=1; coordinates and cell_init held stable until cell_valid&&cell_ready.
  - cell_init = (i==0)||(j==0)||(k==0).
  - On accept → WAIT_WB; cell_valid drops the next cycle.
- WAIT_WB:
  - wb_valid → cells_done+1.
  - If (i,j,k)==(LEN,LEN,LEN) → TB_START.
  - Otherwise advance raster order: k+1; at k==LEN, k=0 and j+1; at j==LEN, j=0 and i+1. Then → ISSUE the next cycle.
- Outstanding requests: at most one, so every predecessor cell (i-1/j-1/k-1 combinations) is always written before a dependent cell issues.
- TB_START: tb_start=1 for exactly one cycle; load the watchdog with 0 → TB_WAIT.
- TB_WAIT:
  - Rising edge of tb_done (registered previous value) → DONE.
  - A level already high on entry is not a rising edge.
  - The watchdog counts each cycle; reaching TB_TIMEOUT → set err_timeout → DONE.
- DONE: done=1 for one cycle → IDLE.
- wb_valid in any state other than WAIT_WB sets err_proto and is otherwise ignored. wb_valid in the same cycle as the ISSUE accept counts as out-of-state.
- Latency, with cell_ready tied high and wb_valid returned 1 cycle after accept:
  - start at cycle t → first cell_valid at t+1.
  - 2 cycles per cell; tb_start at t+1+2*(LEN+1)^3.
- cells_done saturates at (LEN+1)^3; no wrap-around is possible.

Decomposition:
- Package align3_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_WB, TB_START, TB_WAIT, DONE};
  - the command codes shared with traceback (DELETE=3'b000, INSERT=3'b001, KEEP=3'b010, NOTHING=3'b011);
  - a localparam function for the cell count.
- One natural sub-module: align3_idx_walker, the 3-D raster index counter with advance/clear inputs and a last output.

Test Plan:
1. LEN=1, cell_ready=1, wb_valid 1 cycle after accept, tb_done rising 3 cycles after tb_start:
   - issue order (0,0,0),(0,0,1),(0,1,0),…,(1,1,1); only (1,1,1) has cell_init=0;
   - cells_done=8, done pulse, no errors.
2. Backpressure, cell_ready low for 5 cycles on cell (0,1,1) → cell_valid and coordinates are stable throughout; no skipped or duplicated cell.
3. tb_done stuck at 0, TB_TIMEOUT=16 → err_timeout=1 exactly 16 cycles after TB_WAIT entry, then a done pulse; err_timeout stays high until the next start.
4. Spurious wb_valid while in ISSUE → err_proto=1 and cells_done unchanged; the run still completes.
5. Reset asserted in WAIT_WB at cell (1,0,1) → next cycle busy=0, cell_valid=0, no done pulse; a new start re-issues from (0,0,0).
6. start pulsed during TB_WAIT → ignored; exactly one done pulse and cells_done unchanged.

Source files
------------

// File: rtl/align3_pkg.sv
// Shared types for the three-sequence aligner: sequencer states, traceback
// command codes and cube sizing.
package align3_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitWb,
        StTbStart,
        StTbWait,
        StDone
    } ctrl_state_e;

    typedef enum logic [2:0] {
        CmdDelete  = 3'b000,
        CmdInsert  = 3'b001,
        CmdKeep    = 3'b010,
        CmdNothing = 3'b011
    } tb_cmd_e;

    function automatic int unsigned cube_cells(input int unsigned len);
        return (len + 1) * (len + 1) * (len + 1);
    endfunction

endpackage

// File: rtl/align3_idx_walker.sv
// Raster walker over the (LEN+1)^3 cube: k fastest, then j, then i.
// Holds at (LEN,LEN,LEN) once reached until cleared.
module align3_idx_walker
    import align3_pkg::*;
#(
    parameter int unsigned LEN = 7,
    parameter int unsigned IW  = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [IW-1:0] i_o,
    output logic [IW-1:0] j_o,
    output logic [IW-1:0] k_o,
    output logic          last_o
);

    localparam logic [IW-1:0] MaxIdx = IW'(LEN);

    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] k_q, k_d;

    assign last_o = (i_q == MaxIdx) && (j_q == MaxIdx) && (k_q == MaxIdx);
    assign i_o    = i_q;
    assign j_o    = j_q;
    assign k_o    = k_q;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clear_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (advance_i && !last_o) begin
            if (k_q != MaxIdx) begin
                k_d = k_q + 1'b1;
            end else begin
                k_d = '0;
                if (j_q != MaxIdx) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/align3_ctrl.sv
// Alignment sequencer: fills the DP cube one cell at a time (single request
// outstanding), then triggers traceback and waits for it under a watchdog.
module align3_ctrl
    import align3_pkg::*;
#(
    parameter int unsigned LEN        = 7,
    parameter int unsigned IW         = $clog2(LEN + 1),
    parameter int unsigned TB_TIMEOUT = 256,
    parameter int unsigned CW         = $clog2((LEN + 1) ** 3 + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cell_valid,
    input  logic          cell_ready,
    output logic [IW-1:0] cell_i,
    output logic [IW-1:0] cell_j,
    output logic [IW-1:0] cell_k,
    output logic          cell_init,
    input  logic          wb_valid,
    output logic          tb_start,
    input  logic          tb_done,
    output logic [CW-1:0] cells_done,
    output logic          err_timeout,
    output logic          err_proto
);

    localparam int unsigned    NumCells = cube_cells(LEN);
    localparam int unsigned    WdW      = $clog2(TB_TIMEOUT + 1);
    localparam logic [CW-1:0]  CellsMax = CW'(NumCells);
    localparam logic [WdW-1:0] WdLast   = WdW'(TB_TIMEOUT - 1);

    ctrl_state_e    state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cell_valid_q, cell_valid_d;
    logic           tb_start_q, tb_start_d;
    logic [CW-1:0]  cells_done_q, cells_done_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_proto_q, err_proto_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           tb_done_q;

    logic walk_clear, walk_adv, walk_last;

    align3_idx_walker #(
        .LEN (LEN),
        .IW  (IW)
    ) u_walker (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (walk_clear),
        .advance_i (walk_adv),
        .i_o       (cell_i),
        .j_o       (cell_j),
        .k_o       (cell_k),
        .last_o    (walk_last)
    );

    always_comb begin
        state_d       = state_q;
        cells_done_d  = cells_done_q;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q;
        wd_d          = wd_q;
        walk_clear    = 1'b0;
        walk_adv      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cells_done_d  = '0;
                    err_timeout_d = 1'b0;
                    err_proto_d   = 1'b0;
                    walk_clear    = 1'b1;
                    state_d       = StIssue;
                end
            end
            // cell_valid is registered high for the whole of StIssue
            StIssue: begin
                if (cell_ready) state_d = StWaitWb;
            end
            StWaitWb: begin
                if (wb_valid) begin
                    if (cells_done_q != CellsMax) cells_done_d = cells_done_q + 1'b1;
                    if (walk_last) begin
                        state_d = StTbStart;
                    end else begin
                        walk_adv = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StTbStart: begin
                wd_d    = '0;
                state_d = StTbWait;
            end
            StTbWait: begin
                if (tb_done && !tb_done_q) begin
                    state_d = StDone;
                end else if (wd_q == WdLast) begin
                    err_timeout_d = 1'b1;
                    state_d       = StDone;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (wb_valid && (state_q != StWaitWb)) err_proto_d = 1'b1;

        busy_d       = (state_d != StIdle);
        cell_valid_d = (state_d == StIssue);
        tb_start_d   = (state_d == StTbStart);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cell_valid_q  <= 1'b0;
            tb_start_q    <= 1'b0;
            cells_done_q  <= '0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
            wd_q          <= '0;
            tb_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cell_valid_q  <= cell_valid_d;
            tb_start_q    <= tb_start_d;
            cells_done_q  <= cells_done_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
            wd_q          <= wd_d;
            tb_done_q     <= tb_done;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cell_valid  = cell_valid_q;
    assign tb_start    = tb_start_q;
    assign cells_done  = cells_done_q;
    assign err_timeout = err_timeout_q;
    assign err_proto   = err_proto_q;
    assign cell_init   = cell_valid_q && ((cell_i == '0) || (cell_j == '0) || (cell_k == '0));

endmodule
